// File: rtl/xo_dac_spi_writer.sv
// xo_dac_spi_writer
// Serial write engine for the VCXO tuning DAC. Accepts one word per
// valid/ready handshake and shifts it out MSB-first in SPI mode 0. The
// chip-select setup, hold and idle times are set by parameters.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   wr_data   DAC word, sampled only on the accept edge
//   wr_valid  request to send wr_data
//   wr_ready  engine can accept a word this cycle
//   busy      transfer in progress (accept edge until wr_ready returns)
//   done      one-cycle pulse coincident with the nCs rise
//   nCs       active-low chip select (drives the nCsXO pad buffer D input)
//   Sck       serial clock, idle low
//   Mosi      serial data, stable across each Sck rising edge
module xo_dac_spi_writer #(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 24,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_IDLE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 nCs,
  output logic                 Sck,
  output logic                 Mosi
);

  // One counter width serves every phase and the bit index.
  localparam int M1      = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int M2      = (M1 > CS_HOLD) ? M1 : CS_HOLD;
  localparam int M3      = (M2 > CS_IDLE) ? M2 : CS_IDLE;
  localparam int CNT_MAX = (M3 > WORD_BITS) ? M3 : WORD_BITS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
  localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(WORD_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t                state_reg, state_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic [CNT_W-1:0]      bit_reg, bit_next;
  logic [WORD_BITS-1:0]  shift_reg, shift_next;
  logic                  ncs_reg, ncs_next;
  logic                  sck_reg, sck_next;
  logic                  mosi_reg, mosi_next;
  logic                  ready_reg, ready_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;

  logic accept;
  logic phase_end;
  logic sck_fall;
  logic last_bit;

  // ready_reg is only ever high in IDLE or the final GAP cycle.
  assign accept    = wr_valid && ready_reg;
  assign phase_end = (state_reg == SHIFT) && (cnt_reg == DIV_LAST);
  assign sck_fall  = phase_end && sck_reg;
  assign last_bit  = (bit_reg == BIT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (accept) state_next = SETUP;
      SETUP: if (cnt_reg == SETUP_LAST) state_next = SHIFT;
      SHIFT: if (sck_fall && last_bit) state_next = HOLD;
      HOLD:  if (cnt_reg == HOLD_LAST) state_next = GAP;
      // The final GAP edge doubles as the earliest next accept edge.
      GAP:   if (cnt_reg == IDLE_LAST) state_next = accept ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath next values (all outputs leave through registers)
  always_comb begin
    cnt_next   = '0;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    ncs_next   = ncs_reg;
    sck_next   = sck_reg;
    mosi_next  = mosi_reg;
    done_next  = 1'b0;

    // Counter restarts on every state change; in SHIFT it also restarts
    // at each Sck half-period boundary.
    if (state_next == state_reg && state_reg != IDLE) begin
      cnt_next = phase_end ? '0 : cnt_reg + CNT_W'(1);
    end

    if (accept) begin
      shift_next = wr_data;
      mosi_next  = wr_data[WORD_BITS-1];
      ncs_next   = 1'b0;
      bit_next   = '0;
    end

    if (phase_end) sck_next = ~sck_reg;

    // Advance data on every Sck fall except the one ending the last bit.
    if (sck_fall && !last_bit) begin
      shift_next = {shift_reg[WORD_BITS-2:0], 1'b0};
      mosi_next  = shift_reg[WORD_BITS-2];
      bit_next   = bit_reg + CNT_W'(1);
    end

    if (state_reg == HOLD && state_next == GAP) begin
      ncs_next  = 1'b1;
      mosi_next = 1'b0;
      done_next = 1'b1;
    end

    // wr_ready is raised one edge ahead so a handshake can complete on the
    // edge that leaves GAP.
    ready_next = (state_next == IDLE) ||
                 (state_next == GAP && cnt_next == IDLE_LAST);
    busy_next  = (state_next != IDLE) && !ready_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      ncs_reg   <= 1'b1;
      sck_reg   <= 1'b0;
      mosi_reg  <= 1'b0;
      ready_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      ncs_reg   <= ncs_next;
      sck_reg   <= sck_next;
      mosi_reg  <= mosi_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign wr_ready = ready_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign nCs      = ncs_reg;
  assign Sck      = sck_reg;
  assign Mosi     = mosi_reg;

endmodule

// File: tb/tb_xo_dac_spi_writer.sv
// Testbench for xo_dac_spi_writer. Instance 0 uses the default parameters,
// instance 1 the minimum-timing set (CLK_DIV=1, setup/hold/idle=1, 16 bits).
// Stimulus pushes expected transfers into a per-instance queue; a monitor
// per instance reconstructs each transfer from the pins and compares.
// Times are in clk edges relative to the accept edge E0. The "ready return"
// time is the earliest edge at which a new handshake can complete.
module tb_xo_dac_spi_writer;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  wr_valid;
  logic [31:0] wr_data [2];
  logic [1:0]  wr_ready, busy, done, ncs, sck, mosi;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] word;
    int first_rise;
    int ncs_rise;
    int ready_ret;
    int rises;
    int period;
  } exp_t;

  exp_t exp_q [2][$];
  int   done_cnt [2];

  // Hand-computed timing per instance:
  //   first rise = CS_SETUP + CLK_DIV
  //   nCs rise   = CS_SETUP + 2*CLK_DIV*WORD_BITS + CS_HOLD
  //   ready      = nCs rise + CS_IDLE
  int exp_fr  [2] = '{6, 2};
  int exp_ncs [2] = '{196, 34};
  int exp_rdy [2] = '{200, 35};
  int exp_nb  [2] = '{24, 16};
  int idle_min[2] = '{4, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  xo_dac_spi_writer dut0 (
    .clk(clk), .rst(rst[0]), .wr_data(wr_data[0][23:0]), .wr_valid(wr_valid[0]),
    .wr_ready(wr_ready[0]), .busy(busy[0]), .done(done[0]),
    .nCs(ncs[0]), .Sck(sck[0]), .Mosi(mosi[0])
  );

  xo_dac_spi_writer #(
    .CLK_DIV(1), .WORD_BITS(16), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)
  ) dut1 (
    .clk(clk), .rst(rst[1]), .wr_data(wr_data[1][15:0]), .wr_valid(wr_valid[1]),
    .wr_ready(wr_ready[1]), .busy(busy[1]), .done(done[1]),
    .nCs(ncs[1]), .Sck(sck[1]), .Mosi(mosi[1])
  );

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic send(input int d, input logic [31:0] w, input bit keep, input int period);
    exp_t e;
    int n;
    e.word = w; e.first_rise = exp_fr[d]; e.ncs_rise = exp_ncs[d];
    e.ready_ret = exp_rdy[d]; e.rises = exp_nb[d]; e.period = period;
    exp_q[d].push_back(e);
    wr_data[d]  = w;
    wr_valid[d] = 1'b1;
    n = 0;
    while (!wr_ready[d] && n < 500) begin @(negedge clk); n++; end
    if (!wr_ready[d]) begin
      check("accept_timeout", 0, 1);
      wr_valid[d] = 1'b0;
      return;
    end
    $display("dut%0d send 0x%0h at cycle %0d", d, w, cyc + 1);
    @(posedge clk);
    @(negedge clk);
    if (!keep) wr_valid[d] = 1'b0;
  endtask

  task automatic wait_ready(input int d);
    int n = 0;
    while (!wr_ready[d] && n < 1000) begin @(negedge clk); n++; end
    if (!wr_ready[d]) check("ready_timeout", 0, 1);
  endtask

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mon
      logic        p_ncs = 1'b1, p_sck = 1'b0, p_rdy = 1'b0, p_done = 1'b0;
      logic        active = 1'b0, pending = 1'b0;
      logic [31:0] acc;
      int          e0, rises, last_fall, last_rise;
      exp_t        cur;

      always @(negedge clk) begin
        if (rst[gi]) begin
          active  = 1'b0;
          pending = 1'b0;
        end else begin
          if (done[gi]) check("done_at_ncs_rise", {p_ncs, ncs[gi]}, 2'b01);
          if (done[gi]) done_cnt[gi]++;
          if (p_done) check("done_width", done[gi], 0);
          if (sck[gi] && !p_sck) check("sck_with_cs_low", ncs[gi], 0);

          if (p_ncs && !ncs[gi]) begin
            if (exp_q[gi].size() == 0) begin
              check("unexpected_xfer", 1, 0);
            end else begin
              cur = exp_q[gi].pop_front();
              if (cur.period != 0) check("accept_period", cyc - last_fall, cur.period);
              check("idle_gap_ok", int'((cyc - last_rise) >= idle_min[gi]), 1);
              check("busy_at_accept", busy[gi], 1);
              active = 1'b1;
              e0 = cyc; rises = 0; acc = '0;
            end
            last_fall = cyc;
          end

          if (active && sck[gi] && !p_sck) begin
            if (rises == 0) check("first_sck_rise", cyc - e0, cur.first_rise);
            acc = {acc[30:0], mosi[gi]};
            rises++;
          end

          if (active && !p_ncs && ncs[gi]) begin
            check("word", acc, cur.word);
            check("sck_rises", rises, cur.rises);
            check("ncs_rise_time", cyc - e0, cur.ncs_rise);
            check("done_with_ncs", done[gi], 1);
            $display("dut%0d recv 0x%0h rises=%0d ncs_rise=E0+%0d", gi, acc, rises, cyc - e0);
            active = 1'b0; pending = 1'b1; last_rise = cyc;
          end

          if (pending && wr_ready[gi] && !p_rdy) begin
            check("ready_return", cyc + 1 - e0, cur.ready_ret);
            check("busy_cleared", busy[gi], 0);
            pending = 1'b0;
          end
        end
        p_ncs = ncs[gi]; p_sck = sck[gi]; p_rdy = wr_ready[gi]; p_done = done[gi];
      end
    end
  endgenerate

  initial begin
    rst = 2'b11; wr_valid = 2'b00; wr_data[0] = '0; wr_data[1] = '0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_ncs", ncs[d], 1);
      check("rst_sck", sck[d], 0);
      check("rst_mosi", mosi[d], 0);
      check("rst_done", done[d], 0);
      check("rst_ready", wr_ready[d], 0);
      check("rst_busy", busy[d], 0);
    end
    rst = 2'b00;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("ready_after_rst", wr_ready[d], 1);
      check("busy_after_rst", busy[d], 0);
    end

    // Single word, defaults.
    send(0, 32'hA5C3F0, 1'b0, 0);
    wait_ready(0);

    // wr_valid held high, alternating words: 200-cycle cadence.
    send(0, 32'h000001, 1'b1, 0);
    send(0, 32'hFFFFFE, 1'b1, 200);
    send(0, 32'h000001, 1'b0, 200);
    wait_ready(0);

    // A request mid-transfer must be ignored.
    send(0, 32'h5A5A5A, 1'b0, 0);
    repeat (49) @(negedge clk);
    wr_valid[0] = 1'b1; wr_data[0] = 32'h0F0F0F;
    @(negedge clk);
    wr_valid[0] = 1'b0;
    wait_ready(0);

    // Reset at E0+100: outputs must go idle without a clk edge.
    send(0, 32'hC0FFEE, 1'b0, 0);
    repeat (100) @(posedge clk);
    check("mid_xfer_ncs_low", ncs[0], 0);
    #2 rst[0] = 1'b1;
    #1;
    check("async_rst_ncs", ncs[0], 1);
    check("async_rst_sck", sck[0], 0);
    check("async_rst_mosi", mosi[0], 0);
    check("async_rst_done", done[0], 0);
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
    check("ready_after_rst2", wr_ready[0], 1);
    send(0, 32'h123456, 1'b0, 0);
    wait_ready(0);

    // Minimum-timing instance, back-to-back.
    send(1, 32'h8001, 1'b1, 0);
    send(1, 32'h7FFE, 1'b0, 35);
    wait_ready(1);

    repeat (10) @(negedge clk);
    check("queue0_drained", exp_q[0].size(), 0);
    check("queue1_drained", exp_q[1].size(), 0);
    check("done_count0", done_cnt[0], 6);
    check("done_count1", done_cnt[1], 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/xo_dac_spi_writer.md
# xo_dac_spi_writer

Serial write engine for the VCXO tuning DAC. It accepts one DAC word per valid/ready handshake and shifts it out MSB-first on SPI mode 0 (CPOL=0, CPHA=0), with programmable chip-select setup, hold and idle times. Its nCs output drives the D input of the nCsXO LVCMOS33 output buffer directly; Sck and Mosi go to their own pad buffers.

## Interface
- CLK_DIV, default 4: Sck half-period in clk cycles (≥1).
- WORD_BITS, default 24: bits per transfer (2..32).
- CS_SETUP, default 2: clk cycles from nCs fall to the start of the first Sck low phase (≥1).
- CS_HOLD, default 2: clk cycles from the last Sck fall to nCs rise (≥1).
- CS_IDLE, default 4: minimum clk cycles nCs stays high between transfers (≥1).
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- wr_data  in  WORD_BITS  DAC word, sampled on the accept edge only.
- wr_valid  in  1  request to send wr_data.
- wr_ready  out  1  engine can accept a word.
- busy  out  1  high from the accept edge until wr_ready returns.
- done  out  1  one-cycle pulse at the end of each transfer.
- nCs  out  1  active-low DAC chip select; feeds the nCsXO buffer.
- Sck  out  1  serial clock, idle low.
- Mosi  out  1  serial data.

## Operation
- All outputs are registered. Reset values: nCs=1, Sck=0, Mosi=0, wr_ready=0, busy=0, done=0, state IDLE.
- wr_ready rises on the first clk edge after rst deasserts.
- FSM states: IDLE → SETUP → SHIFT → HOLD → GAP → IDLE.
- IDLE: wr_ready=1. An accept occurs at a clk edge where wr_valid&&wr_ready. On that edge:
  - wr_data loads into the shift register.
  - nCs goes to 0, Mosi takes the MSB, busy goes to 1, wr_ready goes to 0.
  - The FSM moves to SETUP.
- SETUP: hold for CS_SETUP cycles with Sck=0, then go to SHIFT.
- SHIFT: WORD_BITS bit periods. Each period is CLK_DIV cycles with Sck=0, then CLK_DIV cycles with Sck=1.
  - On each Sck fall, except after the last bit, Mosi advances to the next bit.
  - After the last high phase, Sck returns to 0 and the FSM moves to HOLD. Mosi holds the LSB.
- HOLD: hold for CS_HOLD cycles with nCs=0.
  - On exit, nCs goes to 1 and Mosi goes to 0.
  - done pulses for exactly one cycle, coincident with the nCs rise.
- GAP: hold for CS_IDLE cycles with nCs=1, then return to IDLE. wr_ready=1 and busy=0 on that same edge.
- wr_valid while not ready is ignored, with no queuing. wr_data changes after the accept have no effect.
- Reset mid-transfer: nCs=1 and Sck=0 immediately (asynchronous); the word is discarded and there is no done pulse.
- Counters are sized to the largest of CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE and WORD_BITS; they must not wrap within a state.

## Timing
- Let E0 be the accept edge.
- nCs falls at E0.
- First Sck rise at E0+CS_SETUP+CLK_DIV.
- Bit k (k=0 is the MSB) is stable from its preceding Sck fall (E0 for k=0) through its rising edge. The DAC samples on the rising edge.
- Last Sck fall at E0+CS_SETUP+2·CLK_DIV·WORD_BITS.
- nCs rises and done pulses at E0+CS_SETUP+2·CLK_DIV·WORD_BITS+CS_HOLD. With defaults this is E0+196.
- wr_ready returns at the nCs rise plus CS_IDLE (defaults: E0+200). The earliest next accept is that same edge, so back-to-back throughput is 200 clk per word with defaults.
- Sck frequency is clk/(2·CLK_DIV).
- No combinational path from any input to any output.

## Test plan
- Reset release, then idle: check nCs=1, Sck=0, Mosi=0 and done=0 during reset. wr_ready=1 from the first edge after release.
- Single write of 0xA5C3F0 with defaults:
  - nCs falls at E0; exactly 24 Sck rises, the first at E0+6.
  - The sampled bit stream equals 0xA5C3F0.
  - nCs rises at E0+196 with done high for 1 cycle; wr_ready returns at E0+200.
- wr_valid held high continuously with alternating words 0x000001 and 0xFFFFFE: accepts happen every 200 cycles, each word is transmitted intact, and nCs is high ≥4 cycles between transfers.
- wr_valid pulsed at E0+50 with a different word: it is ignored, the in-flight word is unchanged, and exactly one done pulse occurs.
- rst asserted at E0+100: nCs=1 and Sck=0 with no clk edge needed. No done pulse. After release, a new write of 0x123456 completes correctly.
- CLK_DIV=1, CS_SETUP=1, CS_HOLD=1, CS_IDLE=1, WORD_BITS=16, word 0x8001:
  - Sck toggles every cycle with 16 rises.
  - nCs rises at E0+34.
  - wr_ready returns at E0+35.
